// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
//
// Purpose:
//   Request/acknowledge bundle between the processor's load/store unit and the
//   data-memory responder. The core drives a request together with its
//   command (load/store), byte address and store data; the responder answers
//   with a one-cycle completion pulse, the registered load data and a busy
//   flag that stays high while an access is in flight.
//
// Signals:
//   req    core -> mem   access request, only sampled while the memory is idle
//   we     core -> mem   1 = store word, 0 = load word
//   addr   core -> mem   byte address of the most-significant byte
//   wdata  core -> mem   store data
//   ack    mem  -> core  one-cycle completion pulse
//   rdata  mem  -> core  load data, held until the next load completes
//   busy   mem  -> core  high while an access is in flight
//
// Modports:
//   master  the processor side
//   slave   the memory side (dmem_responder)
// -----------------------------------------------------------------------------
interface dmem_responder_if #(
  parameter int ADDR_W = 5
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;
  logic              busy;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ack,
    input  rdata,
    input  busy
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ack,
    output rdata,
    output busy
  );

endinterface : dmem_responder_if

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   Multi-cycle data-memory responder: the slave end of the processor's
//   data-memory load/store path. It replaces a zero-latency combinational
//   memory with a request/acknowledge handshake and a programmable number of
//   wait states, so the core can be exercised against a slow memory.
//
//   Storage is DEPTH bytes, byte-addressed and big-endian: the word at byte
//   address a is {mem[a], mem[a+1], mem[a+2], mem[a+3]}, the lowest address
//   holding bits 31:24. The byte offsets are added in ADDR_W bits, so a word
//   that runs past the top of memory wraps to address 0, matching the core's
//   address arithmetic. Unaligned addresses are legal.
//
//   Access sequence:
//     IDLE --req--> WAIT (WAIT_CYCLES edges) --> RESP (ack) --> IDLE
//   With WAIT_CYCLES = 0 the access happens on the accepting edge and the FSM
//   goes straight from IDLE to RESP. A request is only sampled in IDLE, so the
//   minimum spacing between accepted requests is WAIT_CYCLES+2 edges.
//
// Parameters:
//   DEPTH        number of byte locations, power of two
//   ADDR_W       address width, log2(DEPTH)
//   WAIT_CYCLES  wait states between acceptance and response, 0..15
//
// Ports:
//   clk   system clock, all state updates on the rising edge
//   rst   asynchronous active-high reset; discards any in-flight access
//   bus   dmem_responder_if slave modport (req/we/addr/wdata in,
//         ack/rdata/busy out)
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 5,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  // Counter reload value; WAIT_CYCLES = 0 never enters WAIT, so the value is
  // irrelevant there and pinned to zero to keep the cast well defined.
  localparam logic [3:0] WAIT_LOAD_C = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic       NO_WAIT_C   = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // FSM
  state_t            state_r;
  state_t            state_s;

  // Wait-state counter and request captured on the accepting edge
  logic [3:0]        cnt_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;

  // Registered outputs
  logic              ack_r;
  logic [31:0]       rdata_r;

  // Storage
  logic [7:0]        mem_r [DEPTH];

  // Decoded control
  logic              accept_s;
  logic              do_access_s;
  logic              acc_we_s;
  logic [ADDR_W-1:0] acc_addr_s;
  logic [31:0]       acc_wdata_s;
  logic [ADDR_W-1:0] byte_addr_s [4];
  logic [31:0]       load_word_s;
  logic              busy_s;

  // Next-state decode and access-edge detection.
  always_comb begin
    state_s     = state_r;
    accept_s    = 1'b0;
    do_access_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req) begin
          accept_s    = 1'b1;
          // Without wait states the access itself happens on the accepting edge.
          do_access_s = NO_WAIT_C;
          if (NO_WAIT_C) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          do_access_s = 1'b1;
          state_s     = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        // req is deliberately ignored here; the next acceptance is in IDLE.
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Select the command for the access edge: live inputs when the access
  // happens on the accepting edge, the captured copy otherwise.
  always_comb begin
    acc_we_s    = we_r;
    acc_addr_s  = addr_r;
    acc_wdata_s = wdata_r;
    if (state_r == ST_IDLE) begin
      acc_we_s    = bus.we;
      acc_addr_s  = bus.addr;
      acc_wdata_s = bus.wdata;
    end else begin
      acc_we_s    = we_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
    end
  end

  // Byte addresses of the four bytes of the word; the add wraps in ADDR_W bits.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      byte_addr_s[i] = acc_addr_s + ADDR_W'(i);
    end
  end

  // Big-endian assembly of the addressed word.
  always_comb begin
    load_word_s = {mem_r[byte_addr_s[0]], mem_r[byte_addr_s[1]],
                   mem_r[byte_addr_s[2]], mem_r[byte_addr_s[3]]};
  end

  // busy is a pure decode of state so it drops together with the FSM on reset.
  always_comb begin
    busy_s = (state_r != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Wait-state counter: loaded on acceptance, counts down in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 4'd0;
    end else if (accept_s) begin
      cnt_r <= WAIT_LOAD_C;
    end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Capture the request so later input changes cannot reach the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 32'd0;
    end else if (accept_s) begin
      we_r    <= bus.we;
      addr_r  <= bus.addr;
      wdata_r <= bus.wdata;
    end else begin
      we_r    <= we_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // ack is high exactly while the FSM sits in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r <= 1'b0;
    end else begin
      ack_r <= (state_s == ST_RESP);
    end
  end

  // Load data register: updated only by a completing load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= 32'd0;
    end else if (do_access_s && !acc_we_s) begin
      rdata_r <= load_word_s;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // Byte storage: cleared by reset, written big-endian by a completing store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (do_access_s && acc_we_s) begin
      mem_r[byte_addr_s[0]] <= acc_wdata_s[31:24];
      mem_r[byte_addr_s[1]] <= acc_wdata_s[23:16];
      mem_r[byte_addr_s[2]] <= acc_wdata_s[15:8];
      mem_r[byte_addr_s[3]] <= acc_wdata_s[7:0];
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= mem_r[i];
      end
    end
  end

  assign bus.ack   = ack_r;
  assign bus.rdata = rdata_r;
  assign bus.busy  = busy_s;

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. Two instances share the clock: one with
// two wait states, one with none. Inputs are driven and outputs sampled on the
// falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst2;
  logic rst0;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_responder_if #(.ADDR_W(5)) bus2 ();
  dmem_responder_if #(.ADDR_W(5)) bus0 ();

  dmem_responder #(.DEPTH(32), .ADDR_W(5), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  dmem_responder #(.DEPTH(32), .ADDR_W(5), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access on the two-wait-state instance; optionally scrambles addr and
  // wdata every cycle while the access is in WAIT.
  task automatic xact2(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input bit scramble, input string tag);
    int cyc;
    @(negedge clk);
    bus2.req = 1'b1; bus2.we = w; bus2.addr = a; bus2.wdata = d;
    @(negedge clk);
    bus2.req = 1'b0;
    check({tag, "_busy_rise"}, {31'd0, bus2.busy}, 32'd1);
    cyc = 1;
    while (bus2.ack !== 1'b1 && cyc < 10) begin
      if (scramble) begin
        bus2.addr  = 5'(cyc * 7);
        bus2.wdata = 32'(cyc) * 32'h1111_1111;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_ack_lat"}, 32'(cyc), 32'd3);
    check({tag, "_busy_resp"}, {31'd0, bus2.busy}, 32'd1);
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, bus2.ack, bus2.busy}, 32'd0);
  endtask

  // One access on the zero-wait-state instance.
  task automatic xact0(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input string tag);
    int cyc;
    @(negedge clk);
    bus0.req = 1'b1; bus0.we = w; bus0.addr = a; bus0.wdata = d;
    @(negedge clk);
    bus0.req = 1'b0;
    cyc = 1;
    while (bus0.ack !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_ack_lat"}, 32'(cyc), 32'd1);
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, bus0.ack, bus0.busy}, 32'd0);
  endtask

  initial begin
    logic ack_seen;

    rst2 = 1'b1; rst0 = 1'b1;
    bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = 5'd0; bus2.wdata = 32'd0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 5'd0; bus0.wdata = 32'd0;
    #2;
    check("rst_w2", {bus2.ack, bus2.busy, bus2.rdata[29:0]}, 32'd0);
    check("rst_w2_rdata_hi", {30'd0, bus2.rdata[31:30]}, 32'd0);
    check("rst_w0", {bus0.ack, bus0.busy, bus0.rdata[29:0]}, 32'd0);
    @(negedge clk);
    rst2 = 1'b0; rst0 = 1'b0;

    // Aligned store/load and big-endian layout
    xact2(1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0, "st8");
    check("st8_rdata_kept", bus2.rdata, 32'd0);
    xact2(1'b0, 5'd8, 32'd0, 1'b0, "ld8");
    check("ld8", bus2.rdata, 32'hDEAD_BEEF);
    xact2(1'b0, 5'd9, 32'd0, 1'b0, "ld9");
    check("ld9", bus2.rdata, 32'hADBE_EF00);
    xact2(1'b0, 5'd6, 32'd0, 1'b0, "ld6");
    check("ld6", bus2.rdata, 32'h0000_DEAD);

    // Wrap-around at the top of memory
    xact2(1'b1, 5'd30, 32'h1122_3344, 1'b0, "st30");
    xact2(1'b0, 5'd30, 32'd0, 1'b0, "ld30");
    check("ld30", bus2.rdata, 32'h1122_3344);
    xact2(1'b0, 5'd0, 32'd0, 1'b0, "ld0");
    check("ld0", bus2.rdata, 32'h3344_0000);
    xact2(1'b0, 5'd28, 32'd0, 1'b0, "ld28");
    check("ld28", bus2.rdata, 32'h0000_1122);

    // Inputs changing during WAIT must not affect the in-flight store
    xact2(1'b1, 5'd12, 32'hA5A5_A5A5, 1'b1, "st12h");
    xact2(1'b0, 5'd12, 32'd0, 1'b0, "ld12");
    check("ld12", bus2.rdata, 32'hA5A5_A5A5);
    xact2(1'b0, 5'd8, 32'd0, 1'b0, "ld8b");
    check("ld8_untouched", bus2.rdata, 32'hDEAD_BEEF);
    xact2(1'b0, 5'd16, 32'd0, 1'b0, "ld16");
    check("ld16_untouched", bus2.rdata, 32'd0);
    xact2(1'b0, 5'd0, 32'd0, 1'b0, "ld0b");
    check("ld0_untouched", bus2.rdata, 32'h3344_0000);

    // Reset while a store is in WAIT
    @(negedge clk);
    bus2.req = 1'b1; bus2.we = 1'b1; bus2.addr = 5'd4; bus2.wdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus2.req = 1'b0;
    check("rst_pre_busy", {31'd0, bus2.busy}, 32'd1);
    rst2 = 1'b1;
    #1;
    check("rst_async_ack", {31'd0, bus2.ack}, 32'd0);
    check("rst_async_busy", {31'd0, bus2.busy}, 32'd0);
    check("rst_async_rdata", bus2.rdata, 32'd0);
    @(negedge clk);
    rst2 = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus2.ack === 1'b1) ack_seen = 1'b1;
    end
    check("rst_no_ack", {31'd0, ack_seen}, 32'd0);
    xact2(1'b0, 5'd4, 32'd0, 1'b0, "ld4");
    check("ld4_after_rst", bus2.rdata, 32'd0);
    xact2(1'b0, 5'd8, 32'd0, 1'b0, "ld8c");
    check("ld8_after_rst", bus2.rdata, 32'd0);

    // Zero wait states: back-to-back loads with req held high
    xact0(1'b1, 5'd0, 32'h0102_0304, "w0st0");
    xact0(1'b1, 5'd4, 32'h0506_0708, "w0st4");
    @(negedge clk);
    bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 5'd0; bus0.wdata = 32'd0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("w0_busy_%0d", k), {31'd0, bus0.busy}, 32'(k % 2));
      check($sformatf("w0_ack_%0d", k), {31'd0, bus0.ack}, 32'(k % 2));
      if (k % 2 == 1) begin
        check($sformatf("w0_rdata_%0d", k), bus0.rdata,
              (k % 4 == 1) ? 32'h0102_0304 : 32'h0506_0708);
        // A store here would corrupt addr 16 if accepted while busy.
        bus0.we = 1'b1; bus0.addr = 5'd16; bus0.wdata = 32'hFFFF_FFFF;
      end else begin
        bus0.we = 1'b0; bus0.addr = (k % 4 == 2) ? 5'd4 : 5'd0; bus0.wdata = 32'd0;
      end
    end
    bus0.req = 1'b0; bus0.we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    xact0(1'b0, 5'd16, 32'd0, "w0ld16");
    check("w0_ld16_untouched", bus0.rdata, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_dmem_responder
